// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU combined with an iterative multiply/divide unit.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous, active-high reset
//   valid_i  - operation request, accepted when busy is low
//   aluop    - 00 add, 01 sub, 11 slt, 10 decode funct
//   funct    - R-type function field (used when aluop = 10)
//   a, b     - operands
//   result   - registered result of the last completed single-cycle op
//   zero     - registered (result == 0)
//   busy     - high while a multiply/divide is in progress
//   done     - one-cycle completion pulse for every accepted operation
//   illegal  - qualified by done; unsupported funct
//
// Multiply/divide results land in internal HI/LO registers and are read back
// with mfhi/mflo. Both use WIDTH iteration cycles plus one fix-up cycle.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    // Shared iteration registers: {product_hi, product_lo} for MUL,
    // {remainder, dividend/quotient} for DIV.
    logic [WIDTH-1:0] work_hi_reg, work_lo_reg, opb_reg;
    logic             is_div_reg, neg_lo_reg, neg_hi_reg, div0_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg, done_reg, illegal_reg;

    logic             start_mul, start_div, op_signed, op_illegal;
    logic [WIDTH-1:0] op_result;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic             div_ge;
    logic [WIDTH-1:0] div_shift, div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operation decode and single-cycle datapath
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        op_signed  = 1'b0;
        unique case (aluop)
            2'b00: op_result = a + b;
            2'b01: op_result = a - b;
            2'b11: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                unique case (funct)
                    6'b100000, 6'b100001: op_result = a + b;
                    6'b100010, 6'b100011: op_result = a - b;
                    6'b100100: op_result = a & b;
                    6'b100101: op_result = a | b;
                    6'b100110: op_result = a ^ b;
                    6'b100111: op_result = ~(a | b);
                    6'b101010: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b101011: op_result = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'b010000: op_result = hi_reg;
                    6'b010010: op_result = lo_reg;
                    6'b011000: begin start_mul = 1'b1; op_signed = 1'b1; end
                    6'b011001: start_mul = 1'b1;
                    6'b011010: begin start_div = 1'b1; op_signed = 1'b1; end
                    6'b011011: start_div = 1'b1;
                    default:   op_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Operand magnitudes; the iterative engines work on unsigned values only
    assign a_neg = op_signed & a[WIDTH-1];
    assign b_neg = op_signed & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    // One shift-add multiply step: add multiplicand when LSB set, shift right
    assign mul_sum = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opb_reg} : '0);

    // One restoring divide step. The shifted remainder is compared at W+1 bits
    // so a zero divisor simply shifts the dividend into the remainder.
    assign div_ge    = {work_hi_reg, work_lo_reg[WIDTH-1]} >= {1'b0, opb_reg};
    assign div_shift = {work_hi_reg[WIDTH-2:0], work_lo_reg[WIDTH-1]};
    assign div_rem   = div_shift - opb_reg;

    // Sign correction applied on the FIN edge
    assign prod_fix = neg_lo_reg ? (~{work_hi_reg, work_lo_reg} + 1'b1)
                                 : {work_hi_reg, work_lo_reg};
    assign quo_fix  = div0_reg   ? '1
                    : (neg_lo_reg ? (~work_lo_reg + 1'b1) : work_lo_reg);
    assign rem_fix  = neg_hi_reg ? (~work_hi_reg + 1'b1) : work_hi_reg;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (valid_i && start_mul) state_next = MUL;
                else if (valid_i && start_div) state_next = DIV;
            end
            MUL, DIV: if (last_iter) state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            opb_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            div0_reg    <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        if (start_mul || start_div) begin
                            cnt_reg     <= '0;
                            work_hi_reg <= '0;
                            work_lo_reg <= a_mag;
                            opb_reg     <= b_mag;
                            is_div_reg  <= start_div;
                            neg_lo_reg  <= a_neg ^ b_neg;
                            neg_hi_reg  <= a_neg;
                            div0_reg    <= (b == '0);
                        end else begin
                            result_reg  <= op_result;
                            zero_reg    <= (op_result == '0);
                            done_reg    <= 1'b1;
                            illegal_reg <= op_illegal;
                        end
                    end
                end
                MUL: begin
                    cnt_reg     <= cnt_reg + CW'(1);
                    work_hi_reg <= mul_sum[WIDTH:1];
                    work_lo_reg <= {mul_sum[0], work_lo_reg[WIDTH-1:1]};
                end
                DIV: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (div_ge) begin
                        work_hi_reg <= div_rem;
                        work_lo_reg <= {work_lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_reg <= div_shift;
                        work_lo_reg <= {work_lo_reg[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign result  = result_reg;
    assign zero    = zero_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (WIDTH = 32). Stimulus pushes the expected
// {result, zero, illegal} for every accepted op; a monitor pops on each done.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_i = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [5:0]   funct = 6'b000000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         zero, busy, done, illegal;

    alu_mdu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .aluop   (aluop),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .result  (result),
        .zero    (zero),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_txn = 0;
    logic [W-1:0] exp_res = '0;
    logic         exp_zero = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SLT = 2'b11, OP_R = 2'b10;
    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
                           F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110,
                           F_NOR = 6'b100111, F_SLT = 6'b101010, F_SLTU = 6'b101011,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
                           F_BAD = 6'b111111;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one request for a single edge; expected response goes to the scoreboard.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic ei, input bit multi);
        aluop   = op;
        funct   = fn;
        a       = ia;
        b       = ib;
        valid_i = 1'b1;
        if (!multi) begin
            exp_res  = er;
            exp_zero = (er == '0);
        end
        sb_q.push_back({exp_res, exp_zero, ei});
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // Count falling edges until done; also count cycles with busy high.
    task automatic wait_done(input string name, input int exp_n);
        int  n = 0;
        int  nb = 0;
        bit  seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_n));
        check({name, "_busy_cycles"}, 64'(nb), 64'(exp_n - 1));
    endtask

    // Monitor: one scoreboard entry consumed per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_txn++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 with no pending op, expected done=0");
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %0d: result=%h zero=%b illegal=%b", n_txn, result, zero, illegal);
                    check("result", 64'(result), 64'(e.res));
                    check("zero", 64'(zero), 64'(e.zero));
                    check("illegal", 64'(illegal), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        int dcount;

        // Reset state
        #12;
        check("rst_result", 64'(result), 64'h0);
        check("rst_zero", 64'(zero), 64'h1);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_illegal", 64'(illegal), 64'h0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        // Subtract through funct decode: 5 - 7
        issue(OP_R, F_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        check("sub_busy", 64'(busy), 64'h0);
        check("sub_done", 64'(done), 64'h1);

        // Single-cycle directed vectors
        issue(OP_ADD, F_ADD,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0, 1'b0);
        issue(OP_SUB, F_ADD,  32'd10,        32'd10,       32'h0000_0000, 1'b0, 1'b0);
        issue(OP_SLT, F_ADD,  32'hFFFF_FFFF, 32'd1,        32'h0000_0001, 1'b0, 1'b0);
        issue(OP_R,   F_SLTU, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0, 1'b0);
        issue(OP_R,   F_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
        issue(OP_R,   F_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0);
        issue(OP_R,   F_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
        issue(OP_R,   F_NOR,  32'h0,         32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OP_R,   F_SLT,  32'd2,         32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 1'b0);
        issue(OP_R,   F_SLTU, 32'd2,         32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0);
        issue(OP_R,   F_ADDU, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b0, 1'b0);

        // Signed multiply -3 * 4, read back immediately after FIN
        issue(OP_R, F_MULT, 32'hFFFF_FFFD, 32'd4, '0, 1'b0, 1'b1);
        wait_done("mult", W + 2);
        issue(OP_R, F_MFLO, '0, '0, 32'hFFFF_FFF4, 1'b0, 1'b0);
        issue(OP_R, F_MFHI, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Unsigned multiply with an add request held high throughout
        aluop = OP_R; funct = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; valid_i = 1'b1;
        sb_q.push_back({exp_res, exp_zero, 1'b0});
        @(posedge clk);
        #1 aluop = OP_ADD; a = 32'd3; b = 32'd4;
        exp_res = 32'd7; exp_zero = 1'b0;
        sb_q.push_back({exp_res, exp_zero, 1'b0});
        wait_done("multu_held", W + 2);
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        check("held_add_done", 64'(done), 64'h1);
        issue(OP_R, F_MFHI, '0, '0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(OP_R, F_MFLO, '0, '0, 32'h0000_0001, 1'b0, 1'b0);

        // Signed divide -7 / 2
        issue(OP_R, F_DIV, 32'hFFFF_FFF9, 32'd2, '0, 1'b0, 1'b1);
        wait_done("div", W + 2);
        issue(OP_R, F_MFLO, '0, '0, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue(OP_R, F_MFHI, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Most-negative / -1
        issue(OP_R, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b0, 1'b1);
        wait_done("div_ovf", W + 2);
        issue(OP_R, F_MFLO, '0, '0, 32'h8000_0000, 1'b0, 1'b0);
        issue(OP_R, F_MFHI, '0, '0, 32'h0000_0000, 1'b0, 1'b0);

        // Signed divide by zero: -5 / 0
        issue(OP_R, F_DIV, 32'hFFFF_FFFB, 32'd0, '0, 1'b0, 1'b1);
        wait_done("div_zero", W + 2);
        issue(OP_R, F_MFLO, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OP_R, F_MFHI, '0, '0, 32'hFFFF_FFFB, 1'b0, 1'b0);

        // Unsigned divide by zero: 7 / 0
        issue(OP_R, F_DIVU, 32'd7, 32'd0, '0, 1'b0, 1'b1);
        wait_done("divu_zero", W + 2);
        issue(OP_R, F_MFLO, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OP_R, F_MFHI, '0, '0, 32'h0000_0007, 1'b0, 1'b0);

        // Unsupported funct: one-cycle done with illegal, HI/LO untouched
        issue(OP_R, F_BAD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("illegal_done_width", 64'(done), 64'h0);
        check("illegal_flag_clear", 64'(illegal), 64'h0);
        issue(OP_R, F_MFHI, '0, '0, 32'h0000_0007, 1'b0, 1'b0);
        issue(OP_R, F_MFLO, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Reset 10 cycles into a divide aborts it
        issue(OP_R, F_DIVU, 32'd100, 32'd7, '0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        check("abort_result", 64'(result), 64'h0);
        check("abort_zero", 64'(zero), 64'h1);
        sb_q.delete(sb_q.size() - 1);
        exp_res = '0;
        exp_zero = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'h0);
        issue(OP_R, F_MFHI, '0, '0, 32'h0, 1'b0, 1'b0);
        issue(OP_R, F_MFLO, '0, '0, 32'h0, 1'b0, 1'b0);

        // Drain and confirm every expected completion was seen
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
